wb_burst_traffic_gen: RTL and testbench
=======================================

# wb_burst_traffic_gen

Synthesizable Wishbone B3 burst master that writes a deterministic pattern into a memory region, reads it back, and checks it. It sits directly upstream of one `wbs*` slave port of `wb_sdram_ctrl_top`. It replaces the behavioural bus masters for on-board memory bring-up and stays usable in simulation. All traffic is word addressed and uses the controller's 30-bit `adr[31:2]` convention.

## Interface
- `BASE_ADR`, default 30'h0: first word address of the test region.
- `BURST_LEN`, default 4: beats per burst; must be 4, 8 or 16.
- `NR_BURSTS`, default 64: bursts per pass; the region is `NR_BURSTS*BURST_LEN` words.
- `wb_clk` in 1: sole clock.
- `wb_rst` in 1: reset, synchronous and active-high.
- `start` in 1: one-cycle pulse that begins a write pass followed by a read/check pass.
- `wbm_adr_o` out 30: word address.
- `wbm_dat_o` out 32: write data.
- `wbm_sel_o` out 4: byte selects; always 4'hf while `stb` is high.
- `wbm_cti_o` out 3: cycle type; 3'b010 incrementing, 3'b111 last beat.
- `wbm_bte_o` out 2: burst type; always 2'b00 (linear).
- `wbm_we_o` out 1: write enable.
- `wbm_cyc_o` out 1: cycle valid.
- `wbm_stb_o` out 1: strobe.
- `wbm_dat_i` in 32: read data.
- `wbm_ack_i` in 1: acknowledge.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: level; high after both passes complete; cleared by the next accepted `start`.
- `error` out 1: sticky; high if any read mismatched in the current run.
- `err_cnt` out 16: mismatch count; saturates at 16'hffff.
- `first_err_adr` out 30: address of the first mismatch; 0 if none.

## Operation
- Pattern: `pat(a) = {a[15:0], ~a[15:0]}` where `a` is the 30-bit word address. This makes address aliasing and stuck bits visible.
- FSM states: IDLE, WR_BURST, WR_GAP, RD_BURST, RD_GAP, DONE.
- IDLE → WR_BURST on `start`. The accepting edge clears `error`, `err_cnt`, `first_err_adr` and `done`, loads the address counter with `BASE_ADR`, and zeroes the beat and burst counters.
- WR_BURST:
  - `cyc=stb=we=1`, `dat_o=pat(adr_o)`.
  - `cti=010`, or `111` on beat `BURST_LEN-1`.
  - On each `ack`, the address and beat counter advance.
  - An ack on the last beat → WR_GAP.
- WR_GAP: one cycle with `cyc=stb=0`. Next state is WR_BURST, or RD_BURST with the address reloaded to `BASE_ADR` once `NR_BURSTS` bursts are complete.
- RD_BURST: same sequencing with `we=0`. On each `ack`, `dat_i` is compared with `pat(adr_o)` in the same cycle. On a mismatch:
  - `err_cnt` increments (saturating).
  - `error` is set.
  - `first_err_adr` is captured only if `err_cnt` was 0.
- RD_GAP: mirrors WR_GAP and exits to DONE after the last burst.
- DONE: `busy=0`, `done=1`. A `start` → WR_BURST, with the same clears as in IDLE.
- `start` while `busy` is ignored.
- Address counter wraps modulo 2^30 with no special handling.
- `wbm_dat_o` is 0 whenever `we=0`.

## Timing
- Reset values: all `wbm_*` outputs 0, `busy=0`, `done=0`, `error=0`, `err_cnt=0`, `first_err_adr=0`, FSM in IDLE.
- A `wb_rst` asserted mid-burst drops `cyc/stb` at the same edge; no burst completion is attempted.
- `start` sampled at edge N puts `cyc/stb` high after edge N. `busy` is high in the same cycle.
- `stb` and all address, control and data signals are held stable until `ack`, which may arrive after any number of wait states.
- Zero-wait-state slave: one beat per cycle. Burst time is `BURST_LEN` cycles plus 1 gap cycle.
- `ack` outside `cyc&stb` is ignored.
- Compare results update `error` and `err_cnt` on the edge that samples the `ack`.
- `done` rises on the edge leaving the last RD_GAP.

## Structure
- Shared package `wb_pkg`: CTI constants (`CTI_CLASSIC=000`, `CTI_INC=010`, `CTI_EOB=111`), BTE constants, and the FSM state enum.
- One natural sub-module, `wb_pattern_chk`: combinational `pat()` generator plus the saturating error counter and first-error capture.
- Target size: 150–250 lines of RTL.

## Test plan
- `BURST_LEN=4`, `NR_BURSTS=2`, `BASE_ADR=0x100`, zero-wait echo memory model:
  - Writes go to 0x100–0x107 with data 0x0100FEFF..0x0107FEF8.
  - CTI on each burst is 010,010,010,111.
  - Reads return matching data.
  - `done=1`, `error=0`, `err_cnt=0`.
- Same configuration, memory forces bit 0 of the word at 0x105 to 1: `err_cnt=1`, `first_err_adr=0x105`, `error=1`.
- Random 0–5 wait states per beat: `adr`, `dat`, `cti` and `stb` are stable across waits; same results as the first scenario.
- Pulse `start` again during the read pass: ignored. A `start` after `done`: counters clear, and the second run completes with `err_cnt=0`.
- `wb_rst` asserted on the 3rd beat of the 2nd write burst:
  - The following cycle shows `cyc=stb=0` and `busy=0`.
  - A new `start` restarts at `BASE_ADR`.
- Memory with `BURST_LEN=16`, `NR_BURSTS=4` returning all zeros: `err_cnt=64`, `first_err_adr=BASE_ADR`.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the burst traffic generator: cycle/burst
// type encodings, the sequencer state enum and the test data pattern.
package wb_pkg;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INC     = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [1:0] BTE_WRAP4   = 2'b01;
   localparam logic [1:0] BTE_WRAP8   = 2'b10;
   localparam logic [1:0] BTE_WRAP16  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WR_BURST = 3'd1,
      ST_WR_GAP   = 3'd2,
      ST_RD_BURST = 3'd3,
      ST_RD_GAP   = 3'd4,
      ST_DONE     = 3'd5
   } state_t;

   // Address in the upper half, its complement in the lower half: aliasing and stuck bits both show up.
   function automatic logic [31:0] pat(input logic [29:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

endpackage

// File: rtl/wb_pattern_chk.sv
// Read-data checker: expected pattern generation, saturating mismatch counter
// and capture of the first failing word address.
module wb_pattern_chk
   import wb_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_clr,
   input  logic        i_en,
   input  logic [29:0] i_adr,
   input  logic [31:0] i_dat,
   output logic        o_error,
   output logic [15:0] o_err_cnt,
   output logic [29:0] o_first_err_adr
);

   logic [31:0] w_exp;
   logic        w_mis;
   logic        r_error;
   logic [15:0] r_err_cnt;
   logic [29:0] r_first_err_adr;

   // Expected data and mismatch detect for the beat being acknowledged
   always_comb begin
      w_exp = pat(i_adr);
      w_mis = i_en & (i_dat != w_exp);
   end

   // Sticky error, saturating count, first-failure address
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_error         <= 1'b0;
         r_err_cnt       <= 16'h0000;
         r_first_err_adr <= 30'h0;
      end else if (w_mis) begin
         r_error <= 1'b1;
         if (r_err_cnt != 16'hffff) begin
            r_err_cnt <= r_err_cnt + 16'h0001;
         end
         if (r_err_cnt == 16'h0000) begin
            r_first_err_adr <= i_adr;
         end
      end
   end

   assign o_error         = r_error;
   assign o_err_cnt       = r_err_cnt;
   assign o_first_err_adr = r_first_err_adr;

endmodule

// File: rtl/wb_burst_traffic_gen.sv
// Wishbone B3 burst master: writes pat(a) over a region with linear bursts,
// reads it back and checks it. All bus outputs come straight from registers.
module wb_burst_traffic_gen
   import wb_pkg::*;
#(
   parameter logic [29:0] BASE_ADR  = 30'h0,
   parameter int          BURST_LEN = 4,
   parameter int          NR_BURSTS = 64
) (
   input  logic        wb_clk,
   input  logic        wb_rst,
   input  logic        start,
   output logic [29:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   output logic [3:0]  wbm_sel_o,
   output logic [2:0]  wbm_cti_o,
   output logic [1:0]  wbm_bte_o,
   output logic        wbm_we_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [15:0] err_cnt,
   output logic [29:0] first_err_adr
);

   localparam int           BW         = $clog2(NR_BURSTS + 1);
   localparam logic [4:0]    LAST_BEAT  = 5'(BURST_LEN - 1);
   localparam logic [BW-1:0] ALL_BURSTS = BW'(NR_BURSTS);

   state_t        r_state, w_state_nxt;
   logic [29:0]   r_adr, w_adr_nxt;
   logic [31:0]   r_dat, w_dat_nxt;
   logic [3:0]    r_sel, w_sel_nxt;
   logic [2:0]    r_cti, w_cti_nxt;
   logic          r_we, w_we_nxt;
   logic          r_cyc, w_cyc_nxt;
   logic          r_stb, w_stb_nxt;
   logic [4:0]    r_beat, w_beat_nxt;
   logic [BW-1:0] r_burst, w_burst_nxt;
   logic          r_busy, w_busy_nxt;
   logic          r_done, w_done_nxt;
   logic          w_ack;
   logic          w_start_ok;
   logic          w_chk_en;

   // Next-state and next-output logic; everything holds unless a branch changes it
   always_comb begin
      w_state_nxt = r_state;
      w_adr_nxt   = r_adr;
      w_dat_nxt   = r_dat;
      w_cti_nxt   = r_cti;
      w_we_nxt    = r_we;
      w_cyc_nxt   = r_cyc;
      w_stb_nxt   = r_stb;
      w_beat_nxt  = r_beat;
      w_burst_nxt = r_burst;
      w_busy_nxt  = r_busy;
      w_done_nxt  = r_done;
      w_ack       = wbm_ack_i & r_cyc & r_stb;
      w_start_ok  = start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
      w_chk_en    = w_ack & (r_state == ST_RD_BURST);

      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (w_start_ok) begin
               w_state_nxt = ST_WR_BURST;
               w_adr_nxt   = BASE_ADR;
               w_dat_nxt   = pat(BASE_ADR);
               w_cti_nxt   = CTI_INC;
               w_we_nxt    = 1'b1;
               w_cyc_nxt   = 1'b1;
               w_stb_nxt   = 1'b1;
               w_beat_nxt  = 5'd0;
               w_burst_nxt = '0;
               w_busy_nxt  = 1'b1;
               w_done_nxt  = 1'b0;
            end else begin
               w_state_nxt = r_state;
            end
         end
         ST_WR_BURST, ST_RD_BURST: begin
            if (w_ack && (r_beat == LAST_BEAT)) begin
               w_state_nxt = (r_state == ST_WR_BURST) ? ST_WR_GAP : ST_RD_GAP;
               w_adr_nxt   = r_adr + 30'd1;
               w_dat_nxt   = 32'h0;
               w_cti_nxt   = CTI_CLASSIC;
               w_we_nxt    = 1'b0;
               w_cyc_nxt   = 1'b0;
               w_stb_nxt   = 1'b0;
               w_beat_nxt  = 5'd0;
               w_burst_nxt = r_burst + 1'b1;
            end else if (w_ack) begin
               w_adr_nxt   = r_adr + 30'd1;
               w_dat_nxt   = r_we ? pat(r_adr + 30'd1) : 32'h0;
               w_beat_nxt  = r_beat + 5'd1;
               w_cti_nxt   = ((r_beat + 5'd1) == LAST_BEAT) ? CTI_EOB : CTI_INC;
            end else begin
               w_state_nxt = r_state;
            end
         end
         ST_WR_GAP: begin
            w_cyc_nxt  = 1'b1;
            w_stb_nxt  = 1'b1;
            w_cti_nxt  = CTI_INC;
            w_beat_nxt = 5'd0;
            if (r_burst == ALL_BURSTS) begin
               w_state_nxt = ST_RD_BURST;
               w_adr_nxt   = BASE_ADR;
               w_burst_nxt = '0;
               w_we_nxt    = 1'b0;
               w_dat_nxt   = 32'h0;
            end else begin
               w_state_nxt = ST_WR_BURST;
               w_we_nxt    = 1'b1;
               w_dat_nxt   = pat(r_adr);
            end
         end
         ST_RD_GAP: begin
            if (r_burst == ALL_BURSTS) begin
               w_state_nxt = ST_DONE;
               w_busy_nxt  = 1'b0;
               w_done_nxt  = 1'b1;
            end else begin
               w_state_nxt = ST_RD_BURST;
               w_cyc_nxt   = 1'b1;
               w_stb_nxt   = 1'b1;
               w_cti_nxt   = CTI_INC;
               w_beat_nxt  = 5'd0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cyc_nxt   = 1'b0;
            w_stb_nxt   = 1'b0;
            w_we_nxt    = 1'b0;
            w_dat_nxt   = 32'h0;
            w_cti_nxt   = CTI_CLASSIC;
            w_busy_nxt  = 1'b0;
         end
      endcase

      if (w_stb_nxt) begin
         w_sel_nxt = 4'hf;
      end else begin
         w_sel_nxt = 4'h0;
      end
   end

   // State, counters and bus output registers
   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         r_state <= ST_IDLE;
         r_adr   <= 30'h0;
         r_dat   <= 32'h0;
         r_sel   <= 4'h0;
         r_cti   <= CTI_CLASSIC;
         r_we    <= 1'b0;
         r_cyc   <= 1'b0;
         r_stb   <= 1'b0;
         r_beat  <= 5'd0;
         r_burst <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_adr   <= w_adr_nxt;
         r_dat   <= w_dat_nxt;
         r_sel   <= w_sel_nxt;
         r_cti   <= w_cti_nxt;
         r_we    <= w_we_nxt;
         r_cyc   <= w_cyc_nxt;
         r_stb   <= w_stb_nxt;
         r_beat  <= w_beat_nxt;
         r_burst <= w_burst_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   wb_pattern_chk u_chk (
      .i_clk           (wb_clk),
      .i_rst           (wb_rst),
      .i_clr           (w_start_ok),
      .i_en            (w_chk_en),
      .i_adr           (r_adr),
      .i_dat           (wbm_dat_i),
      .o_error         (error),
      .o_err_cnt       (err_cnt),
      .o_first_err_adr (first_err_adr)
   );

   assign wbm_adr_o = r_adr;
   assign wbm_dat_o = r_dat;
   assign wbm_sel_o = r_sel;
   assign wbm_cti_o = r_cti;
   assign wbm_bte_o = BTE_LINEAR;
   assign wbm_we_o  = r_we;
   assign wbm_cyc_o = r_cyc;
   assign wbm_stb_o = r_stb;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

// File: tb/tb_wb_burst_traffic_gen.sv
// Directed bench: echo memory with optional fault and wait states on one DUT,
// an all-zeros memory on a second DUT with long bursts.
module tb_wb_burst_traffic_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   int          n_checks = 0;
   int          n_errors = 0;

   logic        a_start;
   logic [29:0] a_adr;
   logic [31:0] a_dato, a_dati;
   logic [3:0]  a_sel;
   logic [2:0]  a_cti;
   logic [1:0]  a_bte;
   logic        a_we, a_cyc, a_stb, a_ack, a_busy, a_done, a_error;
   logic [15:0] a_errcnt;
   logic [29:0] a_fea;

   logic        b_start;
   logic [29:0] b_adr;
   logic [31:0] b_dato, b_dati;
   logic [3:0]  b_sel;
   logic [2:0]  b_cti;
   logic [1:0]  b_bte;
   logic        b_we, b_cyc, b_stb, b_ack, b_busy, b_done, b_error;
   logic [15:0] b_errcnt;
   logic [29:0] b_fea;

   wb_burst_traffic_gen #(.BASE_ADR(30'h100), .BURST_LEN(4), .NR_BURSTS(2)) u_dut_a (
      .wb_clk(clk), .wb_rst(rst), .start(a_start),
      .wbm_adr_o(a_adr), .wbm_dat_o(a_dato), .wbm_sel_o(a_sel), .wbm_cti_o(a_cti),
      .wbm_bte_o(a_bte), .wbm_we_o(a_we), .wbm_cyc_o(a_cyc), .wbm_stb_o(a_stb),
      .wbm_dat_i(a_dati), .wbm_ack_i(a_ack),
      .busy(a_busy), .done(a_done), .error(a_error), .err_cnt(a_errcnt),
      .first_err_adr(a_fea)
   );

   wb_burst_traffic_gen #(.BASE_ADR(30'h40), .BURST_LEN(16), .NR_BURSTS(4)) u_dut_b (
      .wb_clk(clk), .wb_rst(rst), .start(b_start),
      .wbm_adr_o(b_adr), .wbm_dat_o(b_dato), .wbm_sel_o(b_sel), .wbm_cti_o(b_cti),
      .wbm_bte_o(b_bte), .wbm_we_o(b_we), .wbm_cyc_o(b_cyc), .wbm_stb_o(b_stb),
      .wbm_dat_i(b_dati), .wbm_ack_i(b_ack),
      .busy(b_busy), .done(b_done), .error(b_error), .err_cnt(b_errcnt),
      .first_err_adr(b_fea)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Memory model for DUT A
   logic [31:0] mem_a [0:255];
   logic        fault = 1'b0;
   int          max_wait = 0;
   int          wcnt = 0;
   int          wtgt = 0;
   logic        hold_v = 1'b0;
   logic [34:0] hold_ctl;
   logic [31:0] hold_dat;
   logic [29:0] log_adr [0:63];
   logic [31:0] log_dat [0:63];
   logic [2:0]  log_cti [0:63];
   int          log_n = 0;

   // Slave responses are decided on the falling edge so the DUT sees them settled
   always @(negedge clk) begin
      logic [31:0] rd;
      if (hold_v) begin
         check("hold_ctl", 64'({a_cyc, a_stb, a_we, a_cti, a_adr}), 64'({1'b1, hold_ctl}));
         check("hold_dat", 64'(a_dato), 64'(hold_dat));
      end
      if (a_cyc && a_stb && !rst) begin
         if (wcnt >= wtgt) begin
            a_ack = 1'b1;
            if (a_we) begin
               mem_a[a_adr[7:0]] = a_dato;
               if (log_n < 64) begin
                  log_adr[log_n] = a_adr;
                  log_dat[log_n] = a_dato;
                  log_cti[log_n] = a_cti;
               end
               log_n++;
               a_dati = 32'h0;
            end else begin
               rd = mem_a[a_adr[7:0]];
               if (fault && a_adr == 30'h105) rd[0] = 1'b1;
               a_dati = rd;
            end
            wcnt   = 0;
            wtgt   = $urandom_range(0, max_wait);
            hold_v = 1'b0;
         end else begin
            a_ack    = 1'b0;
            wcnt++;
            hold_v   = 1'b1;
            hold_ctl = {a_stb, a_we, a_cti, a_adr};
            hold_dat = a_dato;
         end
      end else begin
         a_ack  = 1'b0;
         a_dati = 32'h0;
         hold_v = 1'b0;
      end
   end

   // DUT B sees a zero-wait memory that always reads back zero
   always @(negedge clk) begin
      b_ack  = b_cyc & b_stb & ~rst;
      b_dati = 32'h0;
   end

   task automatic start_a();
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
   endtask

   task automatic wait_done_a(input string tag);
      int n = 0;
      while (!a_done && n < 800) begin
         @(negedge clk);
         n++;
      end
      check(tag, 64'(a_done), 64'(1));
   endtask

   initial begin
      int n;
      rst = 1'b1; a_start = 1'b0; b_start = 1'b0;
      for (int i = 0; i < 256; i++) mem_a[i] = 32'hdeadbeef;
      repeat (3) @(negedge clk);
      check("rst_bus", 64'({a_cyc, a_stb, a_we, a_sel, a_cti, a_bte, a_adr}), 64'(0));
      check("rst_dat", 64'(a_dato), 64'(0));
      check("rst_stat", 64'({a_busy, a_done, a_error, a_errcnt, a_fea}), 64'(0));
      rst = 1'b0;
      @(negedge clk);

      // Scenario 1: clean run, zero wait
      log_n = 0;
      start_a();
      check("start_ctl", 64'({a_cyc, a_stb, a_we, a_busy, a_sel, a_cti}), 64'({4'b1111, 4'hf, 3'b010}));
      check("start_adr", 64'(a_adr), 64'(30'h100));
      check("start_dat", 64'(a_dato), 64'(32'h0100feff));
      wait_done_a("s1_done");
      check("s1_nwr", 64'(log_n), 64'(8));
      for (int i = 0; i < 8; i++) begin
         check("s1_wadr", 64'(log_adr[i]), 64'(30'h100 + 30'(i)));
         check("s1_wdat", 64'(log_dat[i]),
               64'({16'h0100 + 16'(i), 16'hfeff - 16'(i)}));
         check("s1_wcti", 64'(log_cti[i]), 64'((i % 4 == 3) ? 3'b111 : 3'b010));
      end
      check("s1_wdat_last", 64'(log_dat[7]), 64'(32'h0107fef8));
      check("s1_stat", 64'({a_busy, a_done, a_error, a_errcnt, a_fea}),
            64'({1'b0, 1'b1, 1'b0, 16'h0, 30'h0}));

      // Scenario 2: bit 0 stuck high at 0x105
      fault = 1'b1;
      start_a();
      wait_done_a("s2_done");
      check("s2_errcnt", 64'(a_errcnt), 64'(1));
      check("s2_fea", 64'(a_fea), 64'(30'h105));
      check("s2_error", 64'(a_error), 64'(1));

      // Scenario 3: random wait states; start must clear the previous error
      fault = 1'b0;
      max_wait = 5;
      log_n = 0;
      start_a();
      check("s3_clr", 64'({a_error, a_errcnt, a_fea, a_done}), 64'(0));
      wait_done_a("s3_done");
      check("s3_nwr", 64'(log_n), 64'(8));
      check("s3_stat", 64'({a_error, a_errcnt, a_fea}), 64'(0));

      // Scenario 4: start during the read pass is ignored
      max_wait = 0;
      log_n = 0;
      start_a();
      n = 0;
      while (!(a_cyc && !a_we) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("s4_rdpass", 64'({a_cyc, a_we}), 64'(2'b10));
      start_a();
      wait_done_a("s4_done");
      check("s4_nwr", 64'(log_n), 64'(8));
      start_a();
      check("s4_restart", 64'({a_done, a_busy}), 64'(2'b01));
      wait_done_a("s4_done2");
      check("s4_errcnt", 64'(a_errcnt), 64'(0));

      // Scenario 5: reset on the 3rd beat of the 2nd write burst
      start_a();
      n = 0;
      while (!(a_cyc && a_we && a_adr == 30'h106) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("s5_hit", 64'(a_adr), 64'(30'h106));
      rst = 1'b1;
      @(negedge clk);
      check("s5_rst", 64'({a_cyc, a_stb, a_busy}), 64'(0));
      rst = 1'b0;
      @(negedge clk);
      start_a();
      check("s5_adr", 64'({a_cyc, a_we, a_adr}), 64'({2'b11, 30'h100}));
      wait_done_a("s5_done");
      check("s5_errcnt", 64'(a_errcnt), 64'(0));

      // Scenario 6: long bursts against an all-zeros memory
      b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      n = 0;
      while (!b_done && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("s6_done", 64'(b_done), 64'(1));
      check("s6_errcnt", 64'(b_errcnt), 64'(64));
      check("s6_fea", 64'(b_fea), 64'(30'h40));
      check("s6_error", 64'(b_error), 64'(1));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
